// File: rtl/regfile_multiport_pkg.sv
// Shared definitions for the multi-port register file: default sizes, FSM state
// encoding and the even-parity helper used when REGFILE_PARITY_EN is defined.
package regfile_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_AW    = 5;
    localparam int PAR_MAX_W = 1024;

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_READY = 1'b1;

    typedef enum logic {
        S_CLEAR = ST_CLEAR,
        S_READY = ST_READY
    } state_e;

    // Callers zero-extend their word; extra zeros do not change parity.
    function automatic logic evenParity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Read/write/control bus of the multi-port register file; the master drives
// requests, the slave (the register file) returns data, Ready and ParErr.
interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    parameter int NR = 2
) ();

    logic            Clear;
    logic            Ready;
    logic [NR-1:0]    RdEn;
    logic [NR*AW-1:0] RdAddr;
    logic [NR*DW-1:0] RdData;
    logic            WrEn;
    logic [AW-1:0]    WrAddr;
    logic [DW-1:0]    WrData;
    logic [NR-1:0]    ParErr;
    logic            ErrInj;

    modport master (
        output Clear, RdEn, RdAddr, WrEn, WrAddr, WrData, ErrInj,
        input  Ready, RdData, ParErr
    );

    modport slave (
        input  Clear, RdEn, RdAddr, WrEn, WrAddr, WrData, ErrInj,
        output Ready, RdData, ParErr
    );

endinterface

// File: rtl/regfile_multiport_read_port.sv
// One synchronous read port: priority mux (clear, zero register, write-through,
// array) into the output register; parity check only with REGFILE_PARITY_EN.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          rdEn,
    input  logic [AW-1:0] rdAddr,
    input  logic [DW-1:0] arrWord,
    input  logic          arrPar,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [DW-1:0] wrData,
    input  logic [AW-1:0] zrIdx,
    input  state_e        state,
    input  logic          clear,
    output logic [DW-1:0] rdData,
    output logic          parErr
);

    logic [DW-1:0] dataNext_s;
    logic          fromArray_s;
    logic [DW-1:0] rdData_r;

    // Source selection; the write-through arm is only reachable when the write commits.
    always_comb begin
        dataNext_s  = {DW{1'b0}};
        fromArray_s = 1'b0;
        if ((state == S_CLEAR) || clear) begin
            dataNext_s = {DW{1'b0}};
        end else if (rdAddr == zrIdx) begin
            dataNext_s = {DW{1'b0}};
        end else if (wrEn && (rdAddr == wrAddr)) begin
            dataNext_s = wrData;
        end else begin
            dataNext_s  = arrWord;
            fromArray_s = 1'b1;
        end
    end

    // Output data register, holds while the port is idle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rdData_r <= {DW{1'b0}};
        end else if (rdEn) begin
            rdData_r <= dataNext_s;
        end
    end

    assign rdData = rdData_r;

`ifdef REGFILE_PARITY_EN
    logic parErr_r;

    // Parity error flag, only meaningful for reads served from the array.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            parErr_r <= 1'b0;
        end else if (rdEn) begin
            parErr_r <= fromArray_s && (arrPar != evenParity(PAR_MAX_W'(arrWord)));
        end
    end

    assign parErr = parErr_r;
`else
    logic unusedPar_s;
    assign unusedPar_s = arrPar ^ fromArray_s;
    assign parErr      = 1'b0;
`endif

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read-port register file with fixed zero register and hardware clear
// sweep. Define REGFILE_PARITY_EN to add per-entry parity and ParErr reporting.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int NR     = 2,
    parameter int ZR_IDX = 2**AW-1
) (
    input logic               Clock,
    input logic               Reset,
    regfile_multiport_if.slave bus
);

    localparam int            DEPTH   = 2**AW;
    localparam logic [AW-1:0] ZR_ADDR = AW'(ZR_IDX);

    state_e        state_r, stateNext_s;
    logic [AW-1:0] clrIdx_r, clrIdxNext_s;
    logic          ready_r;
    logic          wrCommit_s;
    logic [DW-1:0] mem_r [DEPTH];
    logic [NR*DW-1:0] rdDataAll_s;
    logic [NR-1:0]    parErrAll_s;

    assign wrCommit_s = (state_r == S_READY) && bus.WrEn && !bus.Clear && (bus.WrAddr != ZR_ADDR);

    // Next-state logic for the clear sweep; Clear always restarts at entry 0.
    always_comb begin
        stateNext_s  = state_r;
        clrIdxNext_s = clrIdx_r;
        case (state_r)
            S_CLEAR: begin
                if (bus.Clear) begin
                    clrIdxNext_s = {AW{1'b0}};
                end else begin
                    clrIdxNext_s = clrIdx_r + AW'(1);
                    if (&clrIdx_r) begin
                        stateNext_s = S_READY;
                    end else begin
                        stateNext_s = S_CLEAR;
                    end
                end
            end
            S_READY: begin
                if (bus.Clear) begin
                    stateNext_s  = S_CLEAR;
                    clrIdxNext_s = {AW{1'b0}};
                end else begin
                    stateNext_s = S_READY;
                end
            end
            default: begin
                stateNext_s  = S_CLEAR;
                clrIdxNext_s = {AW{1'b0}};
            end
        endcase
    end

    // State, sweep index and Ready registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r  <= S_CLEAR;
            clrIdx_r <= {AW{1'b0}};
            ready_r  <= 1'b0;
        end else begin
            state_r  <= stateNext_s;
            clrIdx_r <= clrIdxNext_s;
            ready_r  <= (stateNext_s == S_READY);
        end
    end

    // Storage array: sweep zeroing in CLEAR, committed writes in READY.
    always_ff @(posedge Clock) begin
        if (state_r == S_CLEAR) begin
            if (clrIdx_r != ZR_ADDR) begin
                mem_r[clrIdx_r] <= {DW{1'b0}};
            end
        end else if (wrCommit_s) begin
            mem_r[bus.WrAddr] <= bus.WrData;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic par_r [DEPTH];

    // Stored parity follows the array; ErrInj flips it to model a corrupted entry.
    always_ff @(posedge Clock) begin
        if (state_r == S_CLEAR) begin
            par_r[clrIdx_r] <= 1'b0;
        end else if (wrCommit_s) begin
            par_r[bus.WrAddr] <= evenParity(PAR_MAX_W'(bus.WrData)) ^ bus.ErrInj;
        end
    end
`else
    logic unusedErrInj_s;
    assign unusedErrInj_s = bus.ErrInj;
`endif

    for (genvar i = 0; i < NR; i++) begin : gRdPort
        logic [AW-1:0] addr_s;
        logic          arrPar_s;
        assign addr_s = bus.RdAddr[i*AW +: AW];
`ifdef REGFILE_PARITY_EN
        assign arrPar_s = par_r[addr_s];
`else
        assign arrPar_s = 1'b0;
`endif
        regfile_read_port #(.DW(DW), .AW(AW)) uRdPort (
            .Clock   (Clock),
            .Reset   (Reset),
            .rdEn    (bus.RdEn[i]),
            .rdAddr  (addr_s),
            .arrWord (mem_r[addr_s]),
            .arrPar  (arrPar_s),
            .wrEn    (bus.WrEn),
            .wrAddr  (bus.WrAddr),
            .wrData  (bus.WrData),
            .zrIdx   (ZR_ADDR),
            .state   (state_r),
            .clear   (bus.Clear),
            .rdData  (rdDataAll_s[i*DW +: DW]),
            .parErr  (parErrAll_s[i])
        );
    end

    assign bus.RdData = rdDataAll_s;
    assign bus.ParErr = parErrAll_s;
    assign bus.Ready  = ready_r;

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport (DW=32, AW=5, NR=2): directed steps
// from the test plan followed by random traffic checked against a behavioural model.
module tb_regfile_multiport;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
    localparam int ZR    = 31;
`ifdef REGFILE_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    regfile_multiport_if #(.DW(DW), .AW(AW), .NR(NR)) bus ();

    regfile_multiport #(.DW(DW), .AW(AW), .NR(NR), .ZR_IDX(ZR)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Behavioural model: contents, injected-error flags, remaining sweep edges.
    logic [31:0] mMem [DEPTH];
    bit          mBad [DEPTH];
    int          mClearLeft;
    logic [31:0] eRd [NR];
    bit          ePe [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            mMem[i] = 32'h0;
            mBad[i] = 1'b0;
        end
        mClearLeft = DEPTH;
        for (int p = 0; p < NR; p++) begin
            eRd[p] = 32'h0;
            ePe[p] = 1'b0;
        end
    endtask

    // One clock cycle: drive at negedge, predict, sample 1 time unit after posedge.
    task automatic step(input logic clr, input logic [1:0] re, input int ra0, input int ra1,
                        input logic we, input int wa, input logic [31:0] wd, input logic ei);
        int  ra [NR];
        bit  inClr;
        ra[0] = ra0;
        ra[1] = ra1;
        bus.Clear  = clr;
        bus.RdEn   = re;
        bus.RdAddr = {5'(ra1), 5'(ra0)};
        bus.WrEn   = we;
        bus.WrAddr = 5'(wa);
        bus.WrData = wd;
        bus.ErrInj = ei;
        inClr = (mClearLeft > 0);
        for (int p = 0; p < NR; p++) begin
            if (re[p]) begin
                if (inClr || clr || ra[p] == ZR) begin
                    eRd[p] = 32'h0;
                    ePe[p] = 1'b0;
                end else if (we && ra[p] == wa) begin
                    eRd[p] = wd;
                    ePe[p] = 1'b0;
                end else begin
                    eRd[p] = mMem[ra[p]];
                    ePe[p] = PAR && mBad[ra[p]];
                end
            end
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mMem[i] = 32'h0;
                mBad[i] = 1'b0;
            end
            mClearLeft = DEPTH;
        end else begin
            if (!inClr && we && wa != ZR) begin
                mMem[wa] = wd;
                mBad[wa] = ei;
            end
            if (mClearLeft > 0) mClearLeft--;
        end
        @(posedge Clock);
        #1;
        chk("ready", {31'h0, bus.Ready}, {31'h0, (mClearLeft == 0)});
        chk("rd0", bus.RdData[31:0], eRd[0]);
        chk("rd1", bus.RdData[63:32], eRd[1]);
        chk("parerr", {30'h0, bus.ParErr}, {30'h0, ePe[1], ePe[0]});
        @(negedge Clock);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'b00, 0, 0, 1'b0, 0, 32'h0, 1'b0);
    endtask

    initial begin
        bus.Clear  = 1'b0;
        bus.RdEn   = '0;
        bus.RdAddr = '0;
        bus.WrEn   = 1'b0;
        bus.WrAddr = '0;
        bus.WrData = '0;
        bus.ErrInj = 1'b0;
        modelReset();
        #23;
        chk("rst_ready", {31'h0, bus.Ready}, 32'h0);
        chk("rst_rd", bus.RdData[31:0] | bus.RdData[63:32], 32'h0);
        chk("rst_parerr", {30'h0, bus.ParErr}, 32'h0);
        @(negedge Clock);
        Reset = 1'b1;

        // Sweep after reset: Ready low for 31 edges, high on the 32nd.
        idle(31);
        chk("ready_before_32", {31'h0, bus.Ready}, 32'h0);
        idle(1);
        chk("ready_at_32", {31'h0, bus.Ready}, 32'h1);
        for (int a = 0; a < DEPTH; a++) step(1'b0, 2'b11, a, DEPTH - 1 - a, 1'b0, 0, 32'h0, 1'b0);

        // Write then read on both ports.
        step(1'b0, 2'b00, 0, 0, 1'b1, 3, 32'hDEADBEEF, 1'b0);
        step(1'b0, 2'b11, 3, 3, 1'b0, 0, 32'h0, 1'b0);
        chk("r3_p0", bus.RdData[31:0], 32'hDEADBEEF);
        chk("r3_p1", bus.RdData[63:32], 32'hDEADBEEF);
        idle(2);
        chk("hold_r3", bus.RdData[63:32], 32'hDEADBEEF);

        // Write-through, then a plain read of the stored value with WrEn low.
        step(1'b0, 2'b00, 0, 0, 1'b1, 7, 32'h11111111, 1'b0);
        step(1'b0, 2'b01, 7, 0, 1'b1, 7, 32'h12345678, 1'b0);
        chk("wt_r7", bus.RdData[31:0], 32'h12345678);
        step(1'b0, 2'b01, 7, 0, 1'b0, 7, 32'hCAFEF00D, 1'b0);
        chk("nowt_r7", bus.RdData[31:0], 32'h12345678);

        // Zero register ignores writes and is never forwarded.
        step(1'b0, 2'b00, 0, 0, 1'b1, ZR, 32'hFFFFFFFF, 1'b0);
        step(1'b0, 2'b11, ZR, ZR, 1'b0, 0, 32'h0, 1'b0);
        chk("zr_read", bus.RdData[31:0], 32'h0);
        step(1'b0, 2'b01, ZR, 0, 1'b1, ZR, 32'hFFFFFFFF, 1'b0);
        chk("zr_wt", bus.RdData[31:0], 32'h0);

        // Clear pulse with a coincident write; reads in CLEAR return 0.
        step(1'b0, 2'b00, 0, 0, 1'b1, 5, 32'hA5A5A5A5, 1'b0);
        step(1'b0, 2'b01, 5, 0, 1'b0, 0, 32'h0, 1'b0);
        chk("r5_filled", bus.RdData[31:0], 32'hA5A5A5A5);
        step(1'b1, 2'b00, 0, 0, 1'b1, 6, 32'h66666666, 1'b0);
        chk("clr_ready_low", {31'h0, bus.Ready}, 32'h0);
        for (int k = 0; k < 31; k++) step(1'b0, 2'b11, 5, 6, 1'b1, 5, 32'h5555AAAA, 1'b0);
        chk("clr_rd_during", bus.RdData[31:0], 32'h0);
        chk("clr_ready_31", {31'h0, bus.Ready}, 32'h0);
        step(1'b0, 2'b00, 0, 0, 1'b0, 0, 32'h0, 1'b0);
        chk("clr_ready_32", {31'h0, bus.Ready}, 32'h1);
        step(1'b0, 2'b11, 5, 6, 1'b0, 0, 32'h0, 1'b0);
        chk("r5_cleared", bus.RdData[31:0], 32'h0);
        chk("r6_dropped", bus.RdData[63:32], 32'h0);

        // Parity injection and recovery (ParErr stays 0 without the parity build).
        step(1'b0, 2'b00, 0, 0, 1'b1, 9, 32'h1, 1'b1);
        step(1'b0, 2'b01, 9, 0, 1'b0, 0, 32'h0, 1'b0);
        chk("par_inj_data", bus.RdData[31:0], 32'h1);
        chk("par_inj_err", {31'h0, bus.ParErr[0]}, {31'h0, PAR});
        step(1'b0, 2'b00, 0, 0, 1'b1, 9, 32'h1, 1'b0);
        step(1'b0, 2'b01, 9, 0, 1'b0, 0, 32'h0, 1'b0);
        chk("par_ok", {31'h0, bus.ParErr[0]}, 32'h0);
        step(1'b0, 2'b01, 9, 0, 1'b1, 9, 32'h3, 1'b1);
        chk("par_wt", {31'h0, bus.ParErr[0]}, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            int    wa;
            int    ra0;
            int    ra1;
            logic  clr;
            wa  = $urandom_range(0, 31);
            ra0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            clr = ($urandom_range(0, 79) == 0);
            step(clr, 2'($urandom_range(0, 3)), ra0, ra1, 1'($urandom_range(0, 1)),
                 wa, $urandom, 1'($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
